// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter: collects WIDTH accepted bits into a word and
// hands it to the consumer through a single holding register with valid/ready.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  input  logic                     io_in_bit,
  output logic                     io_in_ready,
  input  logic                     io_flush,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [WIDTH-1:0]         io_out_bits,
  output logic [$clog2(WIDTH)-1:0] io_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {COLLECT, LAST} phase_e;

  logic [WIDTH-1:0] sr, sr_ins, hr;
  logic [CW-1:0]    cnt;
  logic             full;
  phase_e           phase;
  logic             acc, done;

  // Phase is a pure decode of the bit counter; FULL is tracked separately.
  always_comb begin
    phase = COLLECT;
    if (cnt == LAST_CNT) phase = LAST;
  end

  // The last slot may only be filled if the holding register is free or
  // is being drained on this same edge.
  assign io_in_ready = !io_flush && (phase != LAST || !full || io_out_ready);
  assign acc         = io_in_valid && io_in_ready;
  assign done        = acc && (phase == LAST);

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign sr_ins = {sr[WIDTH-2:0], io_in_bit};
    end else begin : g_lsb
      assign sr_ins = {io_in_bit, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      cnt  <= '0;
      hr   <= '0;
      full <= 1'b0;
    end else begin
      if (io_flush) begin
        sr  <= '0;
        cnt <= '0;
      end else if (done) begin
        hr  <= sr_ins;
        sr  <= '0;
        cnt <= '0;
      end else if (acc) begin
        sr  <= sr_ins;
        cnt <= cnt + CW'(1);
      end
      // A completing word wins over the drain so back-to-back words have no bubble.
      if (done)
        full <= 1'b1;
      else if (full && io_out_ready)
        full <= 1'b0;
    end
  end

  assign io_out_bits  = hr;
  assign io_out_valid = full;
  assign io_count     = cnt;

endmodule

// File: doc/bit_deserializer.md
BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits (legal 2..32).
REQ-002 Parameter: MSB_FIRST, default 1; 1 = first accepted bit lands in bit WIDTH-1, 0 = first accepted bit lands in bit 0.
REQ-003 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: io_in_valid  input  1  serial bit present (driven by upstream mux-tree stage).
REQ-006 Port: io_in_bit  input  1  serial data bit (mux-tree io_out).
REQ-007 Port: io_in_ready  output  1  bit accepted this cycle when io_in_valid && io_in_ready.
REQ-008 Port: io_flush  input  1  discard partially assembled word.
REQ-009 Port: io_out_valid  output  1  io_out_bits holds a complete word.
REQ-010 Port: io_out_ready  input  1  consumer takes word when io_out_valid && io_out_ready.
REQ-011 Port: io_out_bits  output  WIDTH  assembled word.
REQ-012 Port: io_count  output  clog2(WIDTH)  number of bits in the partial word (0..WIDTH-1).

Function
REQ-013 Internal state: shift register SR[WIDTH-1:0], bit counter CNT, holding register HR[WIDTH-1:0], full flag FULL; io_out_bits = HR, io_out_valid = FULL, io_count = CNT.
REQ-014 States: COLLECT (CNT < WIDTH-1), LAST (CNT == WIDTH-1); FULL is orthogonal and indicates a word is waiting for the consumer.
REQ-015 io_in_ready = !io_flush && (CNT != WIDTH-1 || !FULL || io_out_ready); combinational, no dependency on io_in_valid.
REQ-016 Accepted bit with CNT < WIDTH-1: insert bit into SR per MSB_FIRST, CNT <= CNT+1.
REQ-017 Accepted bit with CNT == WIDTH-1: HR <= SR with final bit inserted, FULL <= 1, CNT <= 0, SR <= 0.
REQ-018 Latency: io_out_valid rises in the cycle directly after the edge that accepts the last bit; no additional pipeline delay.
REQ-019 Word handshake: FULL clears on the edge where io_out_valid && io_out_ready, unless REQ-017 completes a new word on the same edge, in which case HR is overwritten and FULL stays 1 (back-to-back words, no bubble).
REQ-020 HR and io_out_bits SHALL stay stable while io_out_valid=1 and io_out_ready=0.
REQ-021 Backpressure: with CNT == WIDTH-1, FULL=1, io_out_ready=0, io_in_ready=0 and no state changes except the consumer side; no bit is lost or duplicated.
REQ-022 io_flush=1: CNT <= 0, SR <= 0 on the next edge; any io_in_bit presented that cycle is not accepted (io_in_ready=0); HR and FULL are unaffected.
REQ-023 io_in_valid=0: SR and CNT hold.
REQ-024 CNT wraps only via REQ-017 and never reaches WIDTH.

Reset
REQ-025 While reset=1, asynchronously: SR=0, CNT=0, HR=0, FULL=0; therefore io_out_valid=0, io_out_bits=0, io_count=0.
REQ-026 io_in_ready = 1 during reset and in the first cycle after release (given io_flush=0).
REQ-027 Reset mid-word or with FULL=1 discards all partial and pending data; no word is emitted for bits accepted before reset.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, io_out_ready=1 -> io_out_valid=1 for one cycle, io_out_bits=0xA5, the cycle after the 8th acceptance.
REQ-029 MSB_FIRST=0, bits 0,0,1,1,0,1,0,1 -> io_out_bits=0xAC; io_count steps 0..7 and returns to 0.
REQ-030 io_out_ready=0, send 0x5A, then 7 bits of the next word -> io_in_ready=0 at CNT=7, HR stays 0x5A; raise io_out_ready -> 0x5A is taken, the 8th bit is accepted on the same edge, and the next word appears with no bubble.
REQ-031 Send 3 bits, assert io_flush with io_in_valid=1 -> io_in_ready=0, io_count=0 next cycle; the next 8 bits form a clean word.
REQ-032 Assert reset asynchronously at CNT=5 with FULL=1 -> io_out_valid=0, io_count=0 immediately, before the next clock edge.
REQ-033 Continuous 32-bit random stream, random io_out_ready -> scoreboard matches all 4 words in order with no loss.
